// File: rtl/led_pkg.sv
// Shared encodings and helpers for the LED bank sequencer.
// Imported by the prescaler and the top-level FSM.
package led_pkg;

    localparam int LED_W = 4;

    typedef enum logic [1:0] {
        MODE_ROTL   = 2'b00,
        MODE_ROTR   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    function automatic logic is_onehot(input logic [LED_W-1:0] v);
        return (v != '0) && ((v & (v - LED_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Step-rate divider: counts to the latched period and pulses tick on wrap.
// The period is re-latched from speed on clear and on every wrap.
module led_prescaler
    import led_pkg::*;
#(
    parameter int DIV_BASE = 1_000_000,
    localparam int CNT_W = $clog2(DIV_BASE * 8)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       hold,
    input  logic [2:0] speed,
    output logic       tick
);

    localparam logic [CNT_W-1:0] BASE = CNT_W'(DIV_BASE);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] spd_mult;
    logic [CNT_W-1:0] last_new;

    // The period itself can equal 2**CNT_W; storing period-1 keeps it in range,
    // and the modular product minus one yields the right value in that case.
    assign spd_mult = CNT_W'(speed) + CNT_W'(1);
    assign last_new = (BASE * spd_mult) - CNT_W'(1);

    assign tick = !clr && !hold && (cnt_q == last_q);

    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        if (clr || tick) begin
            cnt_d  = '0;
            last_d = last_new;
        end else if (!hold) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            last_q <= BASE - CNT_W'(1);
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// LED bank sequencer: IDLE/RUN FSM, bounce direction and next-pattern logic.
// Step timing comes from led_prescaler; all outputs are registered.
module led_sequencer
    import led_pkg::*;
#(
    parameter int DIV_BASE = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pause,
    input  logic [1:0]       mode,
    input  logic [2:0]       speed,
    output logic [LED_W-1:0] leds,
    output logic             step,
    output logic             busy
);

    localparam logic [LED_W-1:0] LED_FIRST = LED_W'(1);
    localparam logic [LED_W-1:0] LED_LAST  = LED_FIRST << (LED_W - 1);

    state_e           state_q, state_d;
    dir_e             dir_q, dir_d;
    logic [LED_W-1:0] leds_q, leds_d;
    logic             step_q, step_d;
    logic             tick;
    logic             presc_clr;
    mode_e            mode_s;

    assign mode_s = mode_e'(mode);

    // Clearing whenever disabled makes a falling en win over a due step.
    assign presc_clr = (state_q == ST_IDLE) || !en;

    led_prescaler #(.DIV_BASE(DIV_BASE)) u_presc (
        .clk   (clk),
        .rst   (rst),
        .clr   (presc_clr),
        .hold  (pause),
        .speed (speed),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        leds_d  = leds_q;
        step_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                leds_d = '0;
                if (en) begin
                    state_d = ST_RUN;
                    leds_d  = LED_FIRST;
                    dir_d   = DIR_LEFT;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    leds_d  = '0;
                end else if (tick) begin
                    step_d = 1'b1;
                    if (mode_s == MODE_BLINK) begin
                        leds_d = (leds_q == '1) ? '0 : '1;
                    end else if (!is_onehot(leds_q)) begin
                        leds_d = LED_FIRST;
                        dir_d  = DIR_LEFT;
                    end else begin
                        case (mode_s)
                            MODE_ROTL: leds_d = {leds_q[LED_W-2:0], leds_q[LED_W-1]};
                            MODE_ROTR: leds_d = {leds_q[0], leds_q[LED_W-1:1]};
                            MODE_BOUNCE: begin
                                if (dir_q == DIR_LEFT) begin
                                    if (leds_q == LED_LAST) begin
                                        dir_d  = DIR_RIGHT;
                                        leds_d = leds_q >> 1;
                                    end else begin
                                        leds_d = leds_q << 1;
                                    end
                                end else begin
                                    if (leds_q == LED_FIRST) begin
                                        dir_d  = DIR_LEFT;
                                        leds_d = leds_q << 1;
                                    end else begin
                                        leds_d = leds_q >> 1;
                                    end
                                end
                            end
                            default: leds_d = leds_q;
                        endcase
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_LEFT;
            leds_q  <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            leds_q  <= leds_d;
            step_q  <= step_d;
        end
    end

    assign leds = leds_q;
    assign step = step_q;
    assign busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: directed scenarios then randomized traffic, all
// checked every cycle against a position/elapsed-time reference model.
module tb_led_sequencer;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       pause;
    logic [1:0] mode;
    logic [2:0] speed;
    logic [3:0] leds;
    logic       step;
    logic       busy;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit m_run;
    int m_leds;
    int m_dir;      // 0 = moving toward bit 3, 1 = toward bit 0
    int m_elapsed;  // cycles since entry or last step
    int m_period;
    bit m_step;

    led_sequencer #(.DIV_BASE(DIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .pause (pause),
        .mode  (mode),
        .speed (speed),
        .leds  (leds),
        .step  (step),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void next_pattern(input int cur, input int md, input int d,
                                         output int nl, output int nd);
        int pos;
        bit oh;
        oh  = (cur == 1) || (cur == 2) || (cur == 4) || (cur == 8);
        pos = (cur == 2) ? 1 : (cur == 4) ? 2 : (cur == 8) ? 3 : 0;
        nd  = d;
        if (md == 3) begin
            nl = (cur == 15) ? 0 : 15;
        end else if (!oh) begin
            nl = 1;
            nd = 0;
        end else if (md == 0) begin
            nl = 1 << ((pos + 1) % 4);
        end else if (md == 1) begin
            nl = 1 << ((pos + 3) % 4);
        end else if (d == 0) begin
            if (pos == 3) begin nd = 1; nl = 4; end
            else nl = 1 << (pos + 1);
        end else begin
            if (pos == 0) begin nd = 0; nl = 2; end
            else nl = 1 << (pos - 1);
        end
    endfunction

    task automatic model_reset();
        m_run = 0; m_leds = 0; m_dir = 0; m_elapsed = 0; m_period = DIV; m_step = 0;
    endtask

    // Advance the model by one clock edge using the inputs held before it.
    task automatic model_edge();
        int nl, nd;
        m_step = 0;
        if (!m_run) begin
            if (en) begin
                m_run = 1; m_leds = 1; m_dir = 0; m_elapsed = 0;
                m_period = DIV * (int'(speed) + 1);
            end
        end else if (!en) begin
            m_run = 0; m_leds = 0; m_elapsed = 0;
        end else if (!pause) begin
            if (m_elapsed + 1 == m_period) begin
                next_pattern(m_leds, int'(mode), m_dir, nl, nd);
                m_leds = nl; m_dir = nd; m_elapsed = 0; m_step = 1;
                m_period = DIV * (int'(speed) + 1);
            end else begin
                m_elapsed++;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("leds", 8'(leds), 8'(m_leds));
        chk("step", 8'(step), 8'(m_step));
        chk("busy", 8'(busy), 8'(m_run));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    // Reset is raised mid-cycle so the asynchronous clear is observed before any edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_leds", 8'(leds), 8'(0));
        chk("rst_step", 8'(step), 8'(0));
        chk("rst_busy", 8'(busy), 8'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        rst = 1'b1; en = 1'b0; pause = 1'b0; mode = 2'b00; speed = 3'd0;
        model_reset();
        #12;
        chk("por_leds", 8'(leds), 8'(0));
        chk("por_busy", 8'(busy), 8'(0));
        @(negedge clk);
        rst = 1'b0;
        run(3);

        // Rotate-left from entry
        en = 1'b1;
        cycle();
        chk("entry_leds", 8'(leds), 8'h01);
        chk("entry_busy", 8'(busy), 8'h01);
        run(4);
        chk("first_step", 8'(step), 8'h01);
        chk("first_leds", 8'(leds), 8'h02);
        run(12);
        chk("wrap_leds", 8'(leds), 8'h01);

        // Bounce, blink, then rotate-right out of all-on
        mode = 2'b10;
        run(40);
        mode = 2'b11;
        run(12);
        mode = 2'b01;
        run(16);

        // Speed changes mid-interval, including the slowest setting
        run(2);
        speed = 3'd1;
        run(22);
        speed = 3'd7;
        run(80);
        speed = 3'd0;
        run(40);

        // Pause mid-interval
        mode = 2'b00;
        run(2);
        pause = 1'b1;
        run(10);
        pause = 1'b0;
        run(10);

        // Drop en on the cycle a step is due
        guard = 0;
        while (!(m_run && (m_elapsed + 1 == m_period)) && guard < 200) begin
            cycle();
            guard++;
        end
        if (guard >= 200) begin
            tests++;
            fails++;
            $error("FAIL due_wait observed=timeout expected=step_due");
        end
        en = 1'b0;
        cycle();
        chk("dis_leds", 8'(leds), 8'h00);
        chk("dis_step", 8'(step), 8'h00);
        run(3);

        // Reset mid-run, then restart
        en = 1'b1;
        run(9);
        do_reset();
        run(8);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            en    = ($urandom % 25) != 0;
            pause = ($urandom % 8) == 0;
            if (($urandom % 12) == 0) mode = 2'($urandom);
            if (($urandom % 20) == 0) speed = (($urandom % 6) == 0) ? 3'd7 : 3'($urandom % 3);
            if (($urandom % 400) == 0) do_reset();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
